audio_fifo_sched: RTL and testbench
===================================

Name: audio_fifo_sched

Overview:
- Schedules and mixes two 16-bit PCM sample streams (music, sfx) into the audio on-chip FIFO through its Avalon-MM write slave (fifo_1_in) and CSR slave.
- Polls the FIFO fill level over the CSR port, maintains a write-credit counter, and never issues a write that could overflow the FIFO.
- Sits in FPGA fabric between the game's sound sources and the soc_system audio path.

Parameters:
- FIFO_DEPTH, 256, capacity of the audio FIFO in 32-bit words.
- MARGIN, 4, words kept free as headroom; credits = FIFO_DEPTH - MARGIN - fill_level.
- LEVEL_ADDR, 3'd0, CSR word address of the fill_level register.
- CW, 9, credit counter width; must satisfy 2**CW > FIFO_DEPTH.

Ports:
- clk  in  1  system clock (clk_clk domain)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  scheduler enable; when 0, finishes the current transaction, then idles
- mus_data  in  16  signed music sample
- mus_valid  in  1  music sample available
- mus_ready  out  1  music sample consumed this cycle
- sfx_data  in  16  signed sfx sample
- sfx_valid  in  1  sfx sample available
- sfx_ready  out  1  sfx sample consumed this cycle
- fifo_address  out  1  FIFO data address, tied 0
- fifo_write  out  1  Avalon write strobe
- fifo_writedata  out  32  {sample, sample}, left = right
- fifo_waitrequest  in  1  Avalon stall
- csr_address  out  3  FIFO CSR address
- csr_read  out  1  CSR read strobe
- csr_readdata  in  32  CSR read data, valid 1 cycle after csr_read (fixed read latency 1, no waitrequest)
- credits  out  CW  current write credits, for debug
- busy  out  1  state != IDLE

Behaviour:
- Reset state: all outputs 0, state IDLE, credits 0, sample register 0.
- FSM states: IDLE, POLL, POLL_WAIT, COLLECT, WRITE.
- IDLE -> POLL when enable=1.
- POLL: csr_read=1 and csr_address=LEVEL_ADDR for exactly 1 cycle, then go to POLL_WAIT.
- POLL_WAIT: capture lvl=csr_readdata[CW-1:0].
  - If lvl >= FIFO_DEPTH-MARGIN: credits=0, go to POLL (repoll continuously).
  - Otherwise: credits = FIFO_DEPTH-MARGIN-lvl, go to COLLECT.
- COLLECT: waits if neither source is valid.
  - Both valid: mus_ready=sfx_ready=1 in the same cycle; sample = sat16(mus+sfx).
  - One valid: assert only that source's ready; sample = its data.
  - Then go to WRITE.
- Saturation: 17-bit signed sum. Result >32767 -> 32767; result < -32768 -> -32768.
- Ready pulses are exactly 1 cycle, asserted only in COLLECT. A source whose valid drops without ready is not an error.
- WRITE: fifo_write=1 and writedata held stable while fifo_waitrequest=1. Write completes on the first cycle with fifo_waitrequest=0. On completion, credits decrements by 1, then:
  - enable=0 -> IDLE
  - credits was 1 (now 0) -> POLL
  - otherwise -> COLLECT
- Latency: sample accepted in cycle N -> fifo_write asserted in cycle N+1. Minimum 2 cycles per sample when credits are available.
- Deassertion of enable:
  - Ignored in WRITE.
  - In COLLECT, POLL_WAIT or POLL: go to IDLE at the next transition point without consuming a sample.
- Asynchronous reset mid-WRITE: fifo_write drops immediately. The sample is lost, which is acceptable.
- credits never underflows. fifo_write is never asserted with credits=0 (assertion).

Decomposition:
- Shared package audio_pkg:
  - state enum
  - sat16 function
  - LEVEL_ADDR and default FIFO_DEPTH constants
- Sub-module audio_mix_sat: combinational 16+16 -> 16 saturating adder, reused later for volume scaling.
- The FSM, credit counter and Avalon drive stay in audio_fifo_sched.

Test Plan:
- Level/credit load: enable=1, csr_readdata=10 -> credits=242, COLLECT reached 2 cycles after POLL.
- Mix: mus=0x1000 and sfx=0x0200 both valid -> both readys 1 for one cycle, fifo_writedata=0x12001200 next cycle.
- Saturation: mus=0x7000, sfx=0x2000 -> writedata=0x7FFF7FFF. mus=0x8000, sfx=0xFFFF -> writedata=0x80008000.
- Stall: fifo_waitrequest=1 for 5 cycles -> fifo_write and writedata stable for 6 cycles, credits decrements once, no ready pulses meanwhile.
- Full FIFO: readdata=252 -> repoll loop with no writes. Readdata changes to 250 -> exactly 2 writes, then POLL.
- Reset/enable: reset_n low mid-WRITE -> all outputs 0 asynchronously. enable=0 during WRITE -> write completes, then IDLE with busy=0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio FIFO scheduler and its mixing datapath.
package audio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      POLL_WAIT,
      COLLECT,
      WRITE
   } state_t;

   localparam int         DEFAULT_FIFO_DEPTH = 256;
   localparam logic [2:0] LEVEL_ADDR         = 3'd0;

   // Overflow shows up as a disagreement between the two top bits of the 17-bit sum.
   function automatic logic signed [15:0] sat16(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
      logic signed [16:0] sum;
      sum = {a[15], a} + {b[15], b};
      if (sum[16] != sum[15]) begin
         return sum[16] ? 16'sh8000 : 16'sh7FFF;
      end
      return sum[15:0];
   endfunction

endpackage

// File: rtl/audio_fifo_sched_if.sv
// Avalon-MM bundle toward the audio FIFO: data write slave plus CSR read slave.
interface audio_fifo_sched_if;
   logic        fifo_address;
   logic        fifo_write;
   logic [31:0] fifo_writedata;
   logic        fifo_waitrequest;
   logic [2:0]  csr_address;
   logic        csr_read;
   logic [31:0] csr_readdata;

   modport master (
      output fifo_address, fifo_write, fifo_writedata, csr_address, csr_read,
      input  fifo_waitrequest, csr_readdata
   );

   modport slave (
      input  fifo_address, fifo_write, fifo_writedata, csr_address, csr_read,
      output fifo_waitrequest, csr_readdata
   );
endinterface

// File: rtl/audio_mix_sat.sv
// Combinational 16+16 -> 16 saturating adder; kept standalone so volume scaling can reuse it.
module audio_mix_sat
   import audio_pkg::*;
(
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   output logic signed [15:0] y
);
   assign y = sat16(a, b);
endmodule

// File: rtl/audio_fifo_sched.sv
// Mixes music and sfx samples into the audio FIFO, gated by credits derived from
// the polled FIFO fill level so a write can never overflow it.
module audio_fifo_sched #(
   parameter int         FIFO_DEPTH = audio_pkg::DEFAULT_FIFO_DEPTH,
   parameter int         MARGIN     = 4,
   parameter logic [2:0] LEVEL_ADDR = audio_pkg::LEVEL_ADDR,
   parameter int         CW         = 9
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic signed [15:0]  mus_data,
   input  logic                mus_valid,
   output logic                mus_ready,
   input  logic signed [15:0]  sfx_data,
   input  logic                sfx_valid,
   output logic                sfx_ready,
   audio_fifo_sched_if.master  av,
   output logic [CW-1:0]       credits,
   output logic                busy
);
   import audio_pkg::*;

   localparam logic [CW-1:0] LIMIT = CW'(FIFO_DEPTH - MARGIN);

   state_t             state_reg;
   logic [CW-1:0]      credits_reg;
   logic signed [15:0] sample_reg;
   logic signed [15:0] sample_next;
   logic signed [15:0] mix;
   logic               csr_read_reg;
   logic [2:0]         csr_address_reg;
   logic               fifo_write_reg;
   logic               busy_reg;
   logic [CW-1:0]      lvl;
   logic               accept;
   logic [31:0]        writedata;
   logic               unused_level_bits;

   assign lvl               = av.csr_readdata[CW-1:0];
   assign unused_level_bits = ^av.csr_readdata[31:CW];

   // Ready must answer valid in the same cycle, so it is decoded from the state register.
   assign accept    = (state_reg == COLLECT) && enable && (mus_valid || sfx_valid);
   assign mus_ready = accept && mus_valid;
   assign sfx_ready = accept && sfx_valid;

   audio_mix_sat u_mix (
      .a (mus_data),
      .b (sfx_data),
      .y (mix)
   );

   always_comb begin
      sample_next = sample_reg;
      if (mus_ready && sfx_ready) begin
         sample_next = mix;
      end else if (mus_ready) begin
         sample_next = mus_data;
      end else if (sfx_ready) begin
         sample_next = sfx_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         credits_reg     <= '0;
         sample_reg      <= '0;
         csr_read_reg    <= 1'b0;
         csr_address_reg <= '0;
         fifo_write_reg  <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (enable) begin
                  state_reg       <= POLL;
                  csr_read_reg    <= 1'b1;
                  csr_address_reg <= LEVEL_ADDR;
                  busy_reg        <= 1'b1;
               end
            end
            POLL: begin
               csr_read_reg    <= 1'b0;
               csr_address_reg <= '0;
               if (enable) begin
                  state_reg <= POLL_WAIT;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            POLL_WAIT: begin
               credits_reg <= (lvl >= LIMIT) ? '0 : LIMIT - lvl;
               if (!enable) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (lvl >= LIMIT) begin
                  state_reg       <= POLL;
                  csr_read_reg    <= 1'b1;
                  csr_address_reg <= LEVEL_ADDR;
               end else begin
                  state_reg <= COLLECT;
               end
            end
            COLLECT: begin
               if (!enable) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (accept) begin
                  sample_reg     <= sample_next;
                  fifo_write_reg <= 1'b1;
                  state_reg      <= WRITE;
               end
            end
            WRITE: begin
               if (!av.fifo_waitrequest) begin
                  fifo_write_reg <= 1'b0;
                  credits_reg    <= credits_reg - CW'(1);
                  if (!enable) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else if (credits_reg == CW'(1)) begin
                     state_reg       <= POLL;
                     csr_read_reg    <= 1'b1;
                     csr_address_reg <= LEVEL_ADDR;
                  end else begin
                     state_reg <= COLLECT;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Left and right channels carry the same mono sample.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign writedata[gi*16 +: 16] = sample_reg;
   end

   assign av.fifo_address   = 1'b0;
   assign av.fifo_write     = fifo_write_reg;
   assign av.fifo_writedata = writedata;
   assign av.csr_read       = csr_read_reg;
   assign av.csr_address    = csr_address_reg;
   assign credits           = credits_reg;
   assign busy              = busy_reg;

   a_write_needs_credit: assert property (@(posedge clk) disable iff (!reset_n)
      fifo_write_reg |-> (credits_reg != '0));

endmodule

// File: tb/tb_audio_fifo_sched.sv
// Scoreboard bench for audio_fifo_sched: expected FIFO words are queued as samples are offered
// and popped when a write completes on the Avalon bus.
module tb_audio_fifo_sched;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [15:0] mus_data;
   logic        mus_valid;
   logic        mus_ready;
   logic [15:0] sfx_data;
   logic        sfx_valid;
   logic        sfx_ready;
   logic [8:0]  credits;
   logic        busy;
   logic        wr;
   logic [8:0]  level;
   logic [31:0] csr_q;

   logic [31:0] sb[$];
   int n_cmp = 0;
   int n_err = 0;
   int n_writes = 0;
   int n_polls = 0;
   int exp_credits = 0;

   audio_fifo_sched_if av();

   audio_fifo_sched dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .mus_data  (mus_data),
      .mus_valid (mus_valid),
      .mus_ready (mus_ready),
      .sfx_data  (sfx_data),
      .sfx_valid (sfx_valid),
      .sfx_ready (sfx_ready),
      .av        (av),
      .credits   (credits),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CSR slave: fixed read latency of one cycle, junk when not answering a read.
   always @(posedge clk) csr_q <= av.csr_read ? {23'd0, level} : 32'hFFFF_FFFF;
   assign av.csr_readdata    = csr_q;
   assign av.fifo_waitrequest = wr;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input logic mv, input logic [15:0] md,
                                               input logic sv, input logic [15:0] sd);
      int s;
      logic [15:0] r;
      if (mv && sv) begin
         s = int'($signed(md)) + int'($signed(sd));
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
         r = s[15:0];
      end else if (mv) begin
         r = md;
      end else begin
         r = sd;
      end
      return {r, r};
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Write monitor: one line per completed FIFO write, compared against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset_n && av.csr_read) n_polls++;
         if (reset_n && av.fifo_write && !av.fifo_waitrequest) begin
            n_writes++;
            if (sb.size() == 0) begin
               check_val("wr_unexpected", av.fifo_write, 1'b0);
            end else begin
               logic [31:0] e;
               e = sb.pop_front();
               $display("WR %0d data=%08h exp=%08h credits=%0d", n_writes, av.fifo_writedata, e, credits);
               check_val("wr_word", av.fifo_writedata, e);
            end
         end
      end
   end

   task automatic wait_poll();
      for (int i = 0; i < 30; i++) begin
         tick();
         #1;
         if (av.csr_read) return;
      end
      check_val("poll_timeout", av.csr_read, 1'b1);
   endtask

   task automatic send(input logic mv, input logic [15:0] md, input logic sv, input logic [15:0] sd,
                       input int stall, input bit drop_en);
      logic [31:0] w;
      w = model_word(mv, md, sv, sd);
      sb.push_back(w);
      mus_valid = mv; mus_data = md; sfx_valid = sv; sfx_data = sd;
      #1;
      for (int i = 0; i < 100; i++) begin
         if (mus_ready || sfx_ready) break;
         tick();
         #1;
      end
      check_val("ready_mus", mus_ready, mv);
      check_val("ready_sfx", sfx_ready, sv);
      if (stall > 0) wr = 1'b1;
      for (int k = 0; k <= stall; k++) begin
         tick();
         if (k == 0) begin
            mus_valid = 1'b0; sfx_valid = 1'b0;
            if (drop_en) enable = 1'b0;
         end
         if (k == stall) wr = 1'b0;
         #1;
         check_val("wr_hold", av.fifo_write, 1'b1);
         check_val("wr_data", av.fifo_writedata, w);
         check_val("no_ready_in_write", {mus_ready, sfx_ready}, 2'b00);
         check_val("cred_hold", credits, exp_credits);
      end
      tick();
      #1;
      exp_credits--;
      check_val("cred_dec", credits, exp_credits);
      check_val("wr_done", av.fifo_write, 1'b0);
      $display("TX mus=%0b/%04h sfx=%0b/%04h stall=%0d exp=%08h", mv, md, sv, sd, stall, w);
   endtask

   initial begin
      int p0;
      int w0;
      bit rdy_seen;
      reset_n = 1'b0; enable = 1'b0; wr = 1'b0; level = '0;
      mus_valid = 1'b0; mus_data = '0; sfx_valid = 1'b0; sfx_data = '0;
      repeat (3) tick();
      #1;
      check_val("rst_write", av.fifo_write, 1'b0);
      check_val("rst_wdata", av.fifo_writedata, 32'h0);
      check_val("rst_csr_read", av.csr_read, 1'b0);
      check_val("rst_csr_addr", av.csr_address, 3'd0);
      check_val("rst_fifo_addr", av.fifo_address, 1'b0);
      check_val("rst_readys", {mus_ready, sfx_ready}, 2'b00);
      check_val("rst_credits", credits, 9'd0);
      check_val("rst_busy", busy, 1'b0);

      tick();
      reset_n = 1'b1;
      tick();
      level = 9'd10; enable = 1'b1;
      wait_poll();
      check_val("poll_addr", av.csr_address, 3'd0);
      check_val("poll_busy", busy, 1'b1);
      tick(); #1;
      check_val("pollwait_csr_read", av.csr_read, 1'b0);
      check_val("pollwait_credits", credits, 9'd0);
      tick(); #1;
      check_val("credit_load", credits, 9'd242);
      exp_credits = 242;

      send(1'b1, 16'h1000, 1'b1, 16'h0200, 0, 1'b0);
      send(1'b1, 16'h7000, 1'b1, 16'h2000, 0, 1'b0);
      send(1'b1, 16'h8000, 1'b1, 16'hFFFF, 0, 1'b0);
      send(1'b1, 16'h1234, 1'b0, 16'h5555, 0, 1'b0);
      send(1'b0, 16'h7777, 1'b1, 16'hABCD, 0, 1'b0);
      send(1'b1, 16'hF000, 1'b1, 16'h0123, 5, 1'b0);

      // Full FIFO: park in IDLE, then present a level at the headroom limit.
      enable = 1'b0;
      tick(); #1;
      check_val("idle_busy", busy, 1'b0);
      level = 9'd252; enable = 1'b1;
      p0 = n_polls; w0 = n_writes; rdy_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         mus_valid = 1'b1; mus_data = 16'h0555;
         #1;
         if (mus_ready) rdy_seen = 1'b1;
      end
      check_val("repoll_loop", (n_polls - p0) >= 8, 1'b1);
      check_val("full_no_write", n_writes - w0, 0);
      check_val("full_no_ready", rdy_seen, 1'b0);
      check_val("full_credits", credits, 9'd0);

      mus_valid = 1'b0;
      level = 9'd250;
      exp_credits = 2;
      send(1'b1, 16'h0042, 1'b0, 16'h0000, 0, 1'b0);
      level = 9'd252;
      send(1'b0, 16'h0000, 1'b1, 16'h0043, 0, 1'b0);
      check_val("poll_after_drain", av.csr_read, 1'b1);
      rdy_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         mus_valid = 1'b1; mus_data = 16'h0666;
         #1;
         if (mus_ready) rdy_seen = 1'b1;
      end
      check_val("drain_two_writes", n_writes - w0, 2);
      check_val("drain_no_ready", rdy_seen, 1'b0);

      // enable dropped while a stalled write is in flight.
      mus_valid = 1'b0;
      level = 9'd10;
      exp_credits = 242;
      send(1'b1, 16'h0100, 1'b1, 16'h0020, 2, 1'b1);
      check_val("en_drop_busy", busy, 1'b0);
      p0 = n_polls;
      repeat (6) tick();
      #1;
      check_val("en_drop_no_poll", n_polls - p0, 0);
      check_val("en_drop_idle_busy", busy, 1'b0);

      // Asynchronous reset while a write is stalled.
      enable = 1'b1;
      mus_valid = 1'b1; mus_data = 16'h4321; sfx_valid = 1'b0;
      #1;
      for (int i = 0; i < 100; i++) begin
         if (mus_ready) break;
         tick();
         #1;
      end
      check_val("rst_test_ready", mus_ready, 1'b1);
      wr = 1'b1;
      tick();
      mus_valid = 1'b0;
      #1;
      check_val("rst_test_writing", av.fifo_write, 1'b1);
      tick();
      reset_n = 1'b0;
      #1;
      check_val("arst_write", av.fifo_write, 1'b0);
      check_val("arst_wdata", av.fifo_writedata, 32'h0);
      check_val("arst_busy", busy, 1'b0);
      check_val("arst_credits", credits, 9'd0);
      check_val("arst_csr_read", av.csr_read, 1'b0);
      wr = 1'b0; enable = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
      check_val("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
